// File: rtl/cam_lane_tx.sv
// cam_lane_tx: imager-side lane word generator.
// Produces the sync lane plus LANES data lanes with frame/line sync codes,
// blanking/training words and a deterministic pixel ramp, one word per clock.
//
// state | meaning
// IDLE  | not running, all lanes TRAIN, waiting for run
// VBLK  | vertical blanking before a frame, all lanes TRAIN
// SOL   | start of line, sync lane FS (row 0) or LS
// DATA  | pixel words, sync lane IMG, data lanes carry the ramp
// EOL   | end of line, sync lane FE (last row) or LE
// HBLK  | horizontal blanking between lines, all lanes TRAIN
module cam_lane_tx #(
    parameter int              W        = 8,
    parameter int              LANES    = 4,
    parameter int              COLS     = 16,
    parameter int              ROWS     = 8,
    parameter int              HBLANK   = 4,
    parameter int              VBLANK   = 8,
    parameter logic [W-1:0]    TRAIN    = 8'hE9,
    parameter logic [W-1:0]    FS       = 8'hAA,
    parameter logic [W-1:0]    LS       = 8'hA5,
    parameter logic [W-1:0]    LE       = 8'h5A,
    parameter logic [W-1:0]    FE       = 8'h55,
    parameter logic [W-1:0]    IMG      = 8'h35,
    parameter logic [LANES:0]  INV_MASK = '0
) (
    input  logic                   c,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   run,
    output logic [(LANES+1)*W-1:0] txd,
    output logic                   frame_active,
    output logic                   line_active,
    output logic                   busy,
    output logic [15:0]            frame_cnt
);

    localparam int TXW     = (LANES + 1) * W;
    localparam int M1      = (COLS > HBLANK) ? COLS : HBLANK;
    localparam int CNT_MAX = (M1 > VBLANK) ? M1 : VBLANK;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [CNT_W-1:0] VB_LOAD  = CNT_W'(VBLANK - 1);
    localparam logic [CNT_W-1:0] HB_LOAD  = CNT_W'(HBLANK - 1);
    localparam logic [CNT_W-1:0] COL_LOAD = CNT_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VBLK,
        S_SOL,
        S_DATA,
        S_EOL,
        S_HBLK
    } state_t;

    // Per-lane inversion expanded to a full-width XOR pattern.
    function automatic logic [TXW-1:0] expand_inv();
        logic [TXW-1:0] m;
        m = '0;
        for (int i = 0; i <= LANES; i++) begin
            m[i*W +: W] = {W{INV_MASK[i]}};
        end
        return m;
    endfunction

    localparam logic [TXW-1:0] INV_EXP   = expand_inv();
    localparam logic [TXW-1:0] TRAIN_ALL = {(LANES+1){TRAIN}};

    // Sync lane carries a code, data lanes idle at TRAIN.
    function automatic logic [TXW-1:0] sync_word(input logic [W-1:0] s);
        return {s, {LANES{TRAIN}}};
    endfunction

    // Pixel ramp: lane k = row + col*LANES + k, truncated to W bits.
    function automatic logic [TXW-1:0] pixel_word(input int row, input int col);
        logic [TXW-1:0] pw;
        pw = '0;
        pw[LANES*W +: W] = IMG;
        for (int k = 0; k < LANES; k++) begin
            pw[k*W +: W] = W'(row + col * LANES + k);
        end
        return pw;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [15:0]      fcnt_q, fcnt_d;
    logic [TXW-1:0]   txd_q, txd_d, raw_d;
    logic             fa_q, fa_d;
    logic             la_q, la_d;
    logic             busy_q, busy_d;

    // Next-state and next-output logic; the output word is chosen for the
    // state being entered so it lines up with that state's cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        col_d   = col_q;
        fcnt_d  = fcnt_q;
        txd_d   = txd_q;
        fa_d    = fa_q;
        la_d    = la_q;
        busy_d  = busy_q;
        raw_d   = TRAIN_ALL;

        if (en) begin
            case (state_q)
                S_IDLE: begin
                    fa_d = 1'b0;
                    la_d = 1'b0;
                    if (run) begin
                        state_d = S_VBLK;
                        cnt_d   = VB_LOAD;
                        busy_d  = 1'b1;
                    end
                end
                S_VBLK: begin
                    if (cnt_q == '0) begin
                        state_d = S_SOL;
                        fa_d    = 1'b1;
                        raw_d   = sync_word((row_q == '0) ? FS : LS);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_SOL: begin
                    state_d = S_DATA;
                    col_d   = '0;
                    cnt_d   = COL_LOAD;
                    la_d    = 1'b1;
                    raw_d   = pixel_word(int'(row_q), 0);
                end
                S_DATA: begin
                    if (cnt_q == '0) begin
                        state_d = S_EOL;
                        la_d    = 1'b0;
                        raw_d   = sync_word((row_q == ROW_LAST) ? FE : LE);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                        col_d = col_q + COL_W'(1);
                        raw_d = pixel_word(int'(row_q), int'(col_q) + 1);
                    end
                end
                S_EOL: begin
                    if (row_q == ROW_LAST) begin
                        fcnt_d = fcnt_q + 16'd1;
                        row_d  = '0;
                        fa_d   = 1'b0;
                        if (run) begin
                            state_d = S_VBLK;
                            cnt_d   = VB_LOAD;
                        end else begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        state_d = S_HBLK;
                        row_d   = row_q + ROW_W'(1);
                        cnt_d   = HB_LOAD;
                    end
                end
                S_HBLK: begin
                    if (cnt_q == '0) begin
                        state_d = S_SOL;
                        raw_d   = sync_word((row_q == '0) ? FS : LS);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    fa_d    = 1'b0;
                    la_d    = 1'b0;
                end
            endcase
            txd_d = raw_d ^ INV_EXP;
        end
    end

    // State, counters and registered outputs; reset returns to IDLE/TRAIN.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            fcnt_q  <= '0;
            txd_q   <= TRAIN_ALL ^ INV_EXP;
            fa_q    <= 1'b0;
            la_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            fcnt_q  <= fcnt_d;
            txd_q   <= txd_d;
            fa_q    <= fa_d;
            la_q    <= la_d;
            busy_q  <= busy_d;
        end
    end

    assign txd          = txd_q;
    assign frame_active = fa_q;
    assign line_active  = la_q;
    assign busy         = busy_q;
    assign frame_cnt    = fcnt_q;

endmodule

// File: tb/tb_cam_lane_tx.sv
// Bench for cam_lane_tx: two instances (plain and inverted lanes) share the
// stimulus; a frame-level model feeds a scoreboard that a monitor drains.
module tb_cam_lane_tx;

    localparam int         COLS   = 4;
    localparam int         ROWS   = 2;
    localparam int         HBLANK = 2;
    localparam int         VBLANK = 3;
    localparam logic [4:0] INV_B  = 5'h13;
    localparam logic [7:0] TRAIN  = 8'hE9;

    logic        c = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        run = 1'b0;
    logic [39:0] txd_a, txd_b;
    logic        fa_a, la_a, busy_a, fa_b, la_b, busy_b;
    logic [15:0] fc_a, fc_b;

    always #5 c = ~c;

    cam_lane_tx #(.COLS(COLS), .ROWS(ROWS), .HBLANK(HBLANK), .VBLANK(VBLANK)) dut_a (
        .c(c), .rst_n(rst_n), .en(en), .run(run), .txd(txd_a),
        .frame_active(fa_a), .line_active(la_a), .busy(busy_a), .frame_cnt(fc_a));

    cam_lane_tx #(.COLS(COLS), .ROWS(ROWS), .HBLANK(HBLANK), .VBLANK(VBLANK),
                  .INV_MASK(INV_B)) dut_b (
        .c(c), .rst_n(rst_n), .en(en), .run(run), .txd(txd_b),
        .frame_active(fa_b), .line_active(la_b), .busy(busy_b), .frame_cnt(fc_b));

    typedef struct {
        logic [39:0] txd;
        logic        fa;
        logic        la;
        logic        busy;
        logic        last;
        logic [15:0] fcnt;
    } item_t;

    item_t frame_q[$];
    item_t sb_q[$];
    item_t cur;
    int    fcnt_m = 0;
    int    total = 0;
    int    bad = 0;

    function automatic item_t idle_item();
        item_t it;
        it.txd = {5{TRAIN}}; it.fa = 0; it.la = 0; it.busy = 0; it.last = 0; it.fcnt = 0;
        return it;
    endfunction

    function automatic item_t mk(input logic [7:0] s, input logic [31:0] d,
                                 input logic fa, input logic la, input logic last);
        item_t it;
        it.txd = {s, d}; it.fa = fa; it.la = la; it.busy = 1; it.last = last; it.fcnt = 0;
        return it;
    endfunction

    function automatic logic [39:0] invx(input logic [39:0] x);
        logic [39:0] y;
        y = x;
        for (int i = 0; i < 5; i++) y[i*8 +: 8] = x[i*8 +: 8] ^ {8{INV_B[i]}};
        return y;
    endfunction

    // One whole frame, written straight from the frame layout rules.
    task automatic build_frame();
        logic [31:0] tr, px;
        tr = {4{TRAIN}};
        for (int i = 0; i < VBLANK; i++) frame_q.push_back(mk(TRAIN, tr, 0, 0, 0));
        for (int r = 0; r < ROWS; r++) begin
            frame_q.push_back(mk((r == 0) ? 8'hAA : 8'hA5, tr, 1, 0, 0));
            for (int col = 0; col < COLS; col++) begin
                for (int k = 0; k < 4; k++) px[k*8 +: 8] = 8'((r + col * 4 + k) % 256);
                frame_q.push_back(mk(8'h35, px, 1, 1, 0));
            end
            frame_q.push_back(mk((r == ROWS - 1) ? 8'h55 : 8'h5A, tr, 1, 0, r == ROWS - 1));
            if (r < ROWS - 1)
                for (int i = 0; i < HBLANK; i++) frame_q.push_back(mk(TRAIN, tr, 1, 0, 0));
        end
    endtask

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advance one expected word per enabled edge.
    initial begin
        cur = idle_item();
        forever begin
            @(posedge c);
            if (!rst_n) begin
                frame_q.delete();
                cur = idle_item();
                fcnt_m = 0;
            end else if (en) begin
                if (cur.last) fcnt_m = (fcnt_m + 1) % 65536;
                if (frame_q.size() == 0 && run) build_frame();
                if (frame_q.size() > 0) cur = frame_q.pop_front();
                else cur = idle_item();
                cur.fcnt = 16'(fcnt_m);
            end
            sb_q.push_back(cur);
        end
    end

    // Monitor: compare both instances against the scoreboard mid-cycle.
    initial begin
        item_t e;
        forever begin
            @(negedge c);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("txd_a", txd_a, e.txd);
                check("flags_a", {37'd0, fa_a, la_a, busy_a}, {37'd0, e.fa, e.la, e.busy});
                check("fcnt_a", {24'd0, fc_a}, {24'd0, e.fcnt});
                check("txd_b", txd_b, invx(e.txd));
                check("flags_b", {37'd0, fa_b, la_b, busy_b}, {37'd0, e.fa, e.la, e.busy});
                check("fcnt_b", {24'd0, fc_b}, {24'd0, e.fcnt});
            end
        end
    end

    task automatic tick();
        @(negedge c);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy_a && n < 100) begin tick(); n++; end
        check(name, {39'd0, busy_a}, 40'd0);
    endtask

    initial begin
        int busy_cnt, last_fs;
        logic seen;

        // Reset, then idle with run low.
        rst_n = 0; en = 1; run = 0;
        repeat (2) tick();
        rst_n = 1;
        repeat (10) tick();
        check("idle_txd", txd_a, 40'hE9E9E9E9E9);
        check("idle_fcnt", {24'd0, fc_a}, 40'd0);

        // Single frame from a one-cycle run pulse.
        run = 1;
        busy_cnt = 0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (i == 0) run = 0;
            if (busy_a) busy_cnt++;
            if (la_a && !seen) begin
                seen = 1;
                check("first_pix_a", txd_a, 40'h3503020100);
                check("first_pix_b", txd_b, 40'hCA0302FEFF);
            end
        end
        check("busy_span", 40'(busy_cnt), 40'd17);
        check("one_frame_cnt", {24'd0, fc_a}, 40'd1);

        // Continuous frames: FS spacing equals the frame period.
        run = 1;
        last_fs = -1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (txd_a[39:32] == 8'hAA) begin
                if (last_fs >= 0) check("fs_period", 40'(i - last_fs), 40'd17);
                last_fs = i;
            end
        end
        run = 0;
        wait_idle("drain_cont");

        // Clock enable toggling through a frame.
        run = 1;
        tick();
        run = 0;
        for (int i = 0; i < 50; i++) begin
            en = ~en;
            tick();
        end
        en = 1;
        wait_idle("drain_en");

        // Asynchronous reset during row 1 pixel data.
        run = 1;
        repeat (14) tick();
        check("pre_reset_la", {39'd0, la_a}, 40'd1);
        rst_n = 0;
        #1;
        check("async_txd_a", txd_a, 40'hE9E9E9E9E9);
        check("async_txd_b", txd_b, invx(40'hE9E9E9E9E9));
        check("async_fcnt", {24'd0, fc_a}, 40'd0);
        tick();
        rst_n = 1;
        repeat (20) tick();
        run = 0;
        wait_idle("drain_rst");

        // Randomized enable, run and occasional reset.
        for (int i = 0; i < 2000; i++) begin
            en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) run = ~run;
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 0;
                tick();
                rst_n = 1;
            end
            tick();
        end
        en = 1;
        run = 0;
        wait_idle("drain_rand");
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
